// File: rtl/counter_run_ctrl.sv
// Run/stop/clear sequencer for the 0-9999 counter: three debounced push-buttons
// drive a small FSM that emits single-cycle tick and clear enables in the clk domain.
module counter_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TICK_DIV        = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    output logic       tick_o,
    output logic       clear_o,
    output logic       dir_o,
    output logic       run_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CLEAR = 2'b10
    } state_t;

    // Button index: 0 = run/stop, 1 = clear, 2 = mode.
    logic [2:0]    sync0_q, sync0_d;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    level_q, level_d;
    logic [2:0]    prev_q, prev_d;
    logic [2:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          run_q, run_d;

    // Synchronize, debounce and edge-detect all three buttons.
    always_comb begin
        sync0_d = {btn_mode, btn_clear, btn_run_stop};
        sync1_d = sync0_q;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = sync1_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Next state, direction, prescaler and the registered output values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_q[1]) begin
                    state_d = CLEAR;
                end else if (press_q[0]) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (press_q[1]) begin
                    state_d = CLEAR;
                end else if (press_q[0]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        dir_d = dir_q ^ press_q[2];

        // The partial period is dropped as soon as RUN is left.
        presc_d = '0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PW'(1);
        end else begin
            presc_d = '0;
        end

        tick_d  = (state_d == RUN) && (presc_d == PS_LAST);
        clear_d = (state_d == CLEAR);
        run_d   = (state_d == RUN);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_q <= 3'b000;
            sync1_q <= 3'b000;
            level_q <= 3'b000;
            prev_q  <= 3'b000;
            press_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= IDLE;
            presc_q <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            run_q   <= run_d;
        end
    end

    assign tick_o  = tick_q;
    assign clear_o = clear_q;
    assign dir_o   = dir_q;
    assign run_o   = run_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl: directed scenarios plus random button
// activity, compared each cycle against a sample-history reference model.
module tb_counter_run_ctrl;

    localparam int D  = 4;
    localparam int TD = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run_stop, btn_clear, btn_mode;
    logic       tick_o, clear_o, dir_o, run_o;
    logic [1:0] state_o;
    logic [5:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: raw-sample histories, levels, presses, state, run length.
    logic [15:0] hist [3];
    logic [2:0]  m_lvl, m_lvl_old, m_press;
    int          m_state;
    int          rc;
    logic        m_dir;
    logic [5:0]  m_out;

    counter_run_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
        .btn_mode(btn_mode), .tick_o(tick_o), .clear_o(clear_o), .dir_o(dir_o),
        .run_o(run_o), .state_o(state_o)
    );

    assign obs = {tick_o, clear_o, dir_o, run_o, state_o};

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) hist[b] = 16'h0000;
        m_lvl = 3'b000; m_lvl_old = 3'b000; m_press = 3'b000;
        m_state = 0; rc = 0; m_dir = 1'b0; m_out = 6'b000000;
    endtask

    // One clock: update the model at the rising edge, return at the falling edge.
    task automatic advance();
        logic [2:0] raw;
        logic [2:0] new_press;
        int         prev_state;
        logic       flip;
        logic       tk;
        @(posedge clk);
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            prev_state = m_state;
            if (m_state == 2)      m_state = 0;
            else if (m_press[1])   m_state = 2;
            else if (m_press[0])   m_state = (m_state == 1) ? 0 : 1;
            if (m_press[2]) m_dir = ~m_dir;
            if (m_state == 1) rc = (prev_state == 1) ? rc + 1 : 0;
            else rc = 0;
            raw = {btn_mode, btn_clear, btn_run_stop};
            for (int b = 0; b < 3; b++) begin
                new_press[b] = m_lvl[b] & ~m_lvl_old[b];
                m_lvl_old[b] = m_lvl[b];
                hist[b] = {hist[b][14:0], raw[b]};
                // Level flips once the last D synchronized samples all disagree with it.
                flip = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (hist[b][k] == m_lvl[b]) flip = 1'b0;
                if (flip) m_lvl[b] = ~m_lvl[b];
            end
            m_press = new_press;
            tk = (m_state == 1) && ((rc % TD) == TD - 1);
            m_out = {tk, (m_state == 2), m_dir, (m_state == 1), 2'(m_state)};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int waited;
        reset = 1'b1; btn_run_stop = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_cmp++;
            if (obs !== 6'b000000) begin
                n_bad++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs, 6'b000000);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)  btn_run_stop = 1'b1;
            if (i == 10) btn_run_stop = 1'b0;
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL reset_setup cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
        end
        waited = 0;
        while (!(m_state == 1 && (rc % TD) == 3) && waited < 20) begin
            advance();
            waited++;
        end
        n_cmp++;
        if (waited >= 20) begin
            n_bad++; $display("FAIL reset_reach_presc3 got=timeout exp=state01_presc3");
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 6'b000000) begin
            n_bad++; $display("FAIL reset_async got=%b exp=%b", obs, 6'b000000);
        end
        model_reset();
        advance();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            advance();
            n_cmp++;
            if (tick_o !== 1'b0 || state_o !== 2'b00 || obs !== m_out) begin
                n_bad++; $display("FAIL reset_after cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
        end
    endtask

    task automatic test_run_timing();
        int n, first_run, first_tick, last_tick;
        first_run = -1; first_tick = -1; last_tick = -1;
        n = cyc + 1;
        btn_run_stop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) btn_run_stop = 1'b0;
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL run_model cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
            if (run_o === 1'b1 && first_run < 0) first_run = cyc;
            if (tick_o === 1'b1) begin
                if (first_tick < 0) first_tick = cyc;
                else begin
                    n_cmp++;
                    if (cyc - last_tick != TD) begin
                        n_bad++; $display("FAIL tick_period got=%0d exp=%0d", cyc - last_tick, TD);
                    end
                end
                last_tick = cyc;
            end
        end
        n_cmp++;
        if (first_run != n + D + 3) begin
            n_bad++; $display("FAIL run_latency got=%0d exp=%0d", first_run, n + D + 3);
        end
        n_cmp++;
        if (first_tick != n + D + 3 + TD - 1) begin
            n_bad++; $display("FAIL first_tick got=%0d exp=%0d", first_tick, n + D + 3 + TD - 1);
        end
        n_cmp++;
        if (state_o !== 2'b01) begin
            n_bad++; $display("FAIL run_after_release got=%b exp=01", state_o);
        end
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < 8);
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL run_stop cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
        end
        n_cmp++;
        if (state_o !== 2'b00) begin
            n_bad++; $display("FAIL run_stopped got=%b exp=00", state_o);
        end
    endtask

    task automatic test_glitch();
        int len, changes;
        logic [1:0] prev;
        len = $urandom_range(1, D - 1);
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < len);
            advance();
            n_cmp++;
            if (state_o !== 2'b00 || tick_o !== 1'b0 || obs !== m_out) begin
                n_bad++; $display("FAIL glitch_short len=%0d got=%b exp=%b", len, obs, m_out);
            end
        end
        changes = 0;
        prev = state_o;
        for (int i = 0; i < 38; i++) begin
            btn_run_stop = (i < 10) || (i >= 13 && i < 23);
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL glitch_dropout cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
            if (state_o !== prev) changes++;
            prev = state_o;
        end
        n_cmp++;
        if (changes != 1 || state_o !== 2'b01) begin
            n_bad++; $display("FAIL dropout_one_press got=%0d/%b exp=1/01", changes, state_o);
        end
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < 8);
            advance();
        end
    endtask

    task automatic test_clear_run();
        int wait_n, n_clear;
        logic [1:0] prev;
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < 8);
            advance();
        end
        n_cmp++;
        if (state_o !== 2'b01) begin
            n_bad++; $display("FAIL clear_setup got=%b exp=01", state_o);
        end
        wait_n = $urandom_range(0, 7);
        for (int i = 0; i < wait_n; i++) advance();
        n_clear = 0;
        prev = state_o;
        for (int i = 0; i < 30; i++) begin
            btn_clear = (i < 8);
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL clear_model cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
            if (state_o === 2'b10) begin
                n_clear++;
                n_cmp++;
                if (clear_o !== 1'b1 || run_o !== 1'b0 || tick_o !== 1'b0 || prev !== 2'b01) begin
                    n_bad++; $display("FAIL clear_entry got=%b prev=%b exp=clr1_run0_prev01", obs, prev);
                end
            end else if (prev === 2'b10) begin
                n_cmp++;
                if (state_o !== 2'b00 || clear_o !== 1'b0) begin
                    n_bad++; $display("FAIL clear_exit got=%b exp=000000-ish state00", obs);
                end
            end
            if (n_clear > 0 && tick_o === 1'b1) begin
                n_bad++; $display("FAIL clear_tick got=1 exp=0");
            end
            prev = state_o;
        end
        n_cmp++;
        if (n_clear != 1 || state_o !== 2'b00) begin
            n_bad++; $display("FAIL clear_once got=%0d/%b exp=1/00", n_clear, state_o);
        end
    endtask

    task automatic test_simultaneous();
        int n_clear, n_run;
        n_clear = 0; n_run = 0;
        for (int i = 0; i < 25; i++) begin
            btn_run_stop = (i < 8);
            btn_clear    = (i < 8);
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL simul_model cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
            if (state_o === 2'b10) n_clear++;
            if (run_o !== 1'b0) n_run++;
        end
        n_cmp++;
        if (n_clear != 1 || n_run != 0 || state_o !== 2'b00) begin
            n_bad++; $display("FAIL simul_clear_wins got=clr%0d_run%0d_%b exp=clr1_run0_00", n_clear, n_run, state_o);
        end
    endtask

    task automatic test_direction();
        int n1, n_chg, last_tick;
        int chg [2];
        logic prev_dir;
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < 8);
            advance();
        end
        n_cmp++;
        if (dir_o !== 1'b0 || state_o !== 2'b01) begin
            n_bad++; $display("FAIL dir_setup got=%b/%b exp=0/01", dir_o, state_o);
        end
        n1 = cyc + 1;
        n_chg = 0; chg[0] = -1; chg[1] = -1; last_tick = -1;
        prev_dir = dir_o;
        for (int i = 0; i < 40; i++) begin
            btn_mode = (i < 6) || (i >= 14 && i < 20);
            advance();
            n_cmp++;
            if (obs !== m_out) begin
                n_bad++; $display("FAIL dir_model cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
            if (dir_o !== prev_dir) begin
                if (n_chg < 2) chg[n_chg] = cyc;
                n_chg++;
            end
            prev_dir = dir_o;
            if (tick_o === 1'b1) begin
                if (last_tick >= 0) begin
                    n_cmp++;
                    if (cyc - last_tick != TD) begin
                        n_bad++; $display("FAIL dir_tick_period got=%0d exp=%0d", cyc - last_tick, TD);
                    end
                end
                last_tick = cyc;
            end
        end
        n_cmp++;
        if (n_chg != 2 || chg[0] != n1 + D + 3 || chg[1] != n1 + 14 + D + 3 || dir_o !== 1'b0) begin
            n_bad++; $display("FAIL dir_toggle got=%0d@%0d,%0d exp=2@%0d,%0d", n_chg, chg[0], chg[1],
                              n1 + D + 3, n1 + 14 + D + 3);
        end
        for (int i = 0; i < 20; i++) begin
            btn_run_stop = (i < 8);
            advance();
        end
    endtask

    task automatic test_random();
        int   left [3];
        logic val  [3];
        for (int b = 0; b < 3; b++) begin left[b] = 0; val[b] = 1'b0; end
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (left[b] == 0) begin
                    val[b]  = ($urandom_range(0, 2) == 0);
                    left[b] = $urandom_range(1, 12);
                end
                left[b]--;
            end
            btn_run_stop = val[0]; btn_clear = val[1]; btn_mode = val[2];
            advance();
            n_cmp++;
            if (obs !== m_out || (tick_o === 1'b1 && clear_o === 1'b1)) begin
                n_bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, m_out);
            end
        end
    endtask

    initial begin
        reset = 1'b1; btn_run_stop = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
        model_reset();
        test_reset();
        test_run_timing();
        test_glitch();
        test_clear_run();
        test_simultaneous();
        test_direction();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
